// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter and the ALU it fronts.
// Opcode values here must match the ALU model's decode.
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int ALU_TW = 4;
   localparam int STAT_W = 16;

   localparam logic [ALU_TW-1:0] OP_ADD = 4'd0;
   localparam logic [ALU_TW-1:0] OP_SUB = 4'd1;
   localparam logic [ALU_TW-1:0] OP_AND = 4'd2;
   localparam logic [ALU_TW-1:0] OP_OR  = 4'd3;
   localparam logic [ALU_TW-1:0] OP_XOR = 4'd4;
   localparam logic [ALU_TW-1:0] OP_SLL = 4'd5;
   localparam logic [ALU_TW-1:0] OP_SRL = 4'd6;

   // Width of an index or counter that must hold values 0..n-1, never zero bits.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
// Produces a one-hot grant, its binary index and an any-request flag.
module rr_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   int j;

   // NOTE: every output gets a default before the search loop so no path leaves
   // a value unassigned; otherwise synthesis infers latches.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one fixed-latency ALU among NREQ requesters, one operation in flight.
// Optional per-requester grant counters when ALU_ARB_STATS_EN is defined.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DW      = 32,
   parameter int TW      = ALU_TW,
   parameter int ALU_LAT = 1,
   parameter int IW      = idx_w(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*DW-1:0] req_a,
   input  logic [NREQ*DW-1:0] req_b,
   input  logic [NREQ*TW-1:0] req_type,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IW-1:0]     rsp_id,
   output logic [DW-1:0]     rsp_data,
   output logic [DW-1:0]     alu_a,
   output logic [DW-1:0]     alu_b,
   output logic [TW-1:0]     alu_type,
   input  logic [DW-1:0]     alu_out
`ifdef ALU_ARB_STATS_EN
  ,output logic [NREQ*STAT_W-1:0] grant_cnt
`endif
);

   localparam int CW = idx_w(ALU_LAT);

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   own_id;
   logic [CW-1:0]   cnt;
   logic [NREQ-1:0] win_grant;
   logic [IW-1:0]   win_idx;
   logic            any_req;

   logic [DW-1:0]   a_arr [NREQ];
   logic [DW-1:0]   b_arr [NREQ];
   logic [TW-1:0]   t_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[i*DW +: DW];
      assign b_arr[i] = req_b[i*DW +: DW];
      assign t_arr[i] = req_type[i*TW +: TW];
   end

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (win_grant),
      .idx   (win_idx),
      .any   (any_req)
   );

   // Gated by rst_n so no handshake can complete while the FSM is held in reset.
   assign req_ready = (rst_n && state == IDLE) ? win_grant : '0;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         own_id    <= '0;
         cnt       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_type  <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  alu_a    <= a_arr[win_idx];
                  alu_b    <= b_arr[win_idx];
                  alu_type <= t_arr[win_idx];
                  own_id   <= win_idx;
                  cnt      <= CW'(ALU_LAT - 1);
                  state    <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  rsp_data  <= alu_out;
                  rsp_id    <= own_id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  ptr       <= (own_id == IW'(NREQ - 1)) ? '0 : own_id + 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   logic [STAT_W-1:0] stat_q [NREQ];

   // NOTE: counters are visible outputs with a defined reset value, so this
   // small array is reset explicitly, unlike a data RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
      end else if (state == IDLE && any_req) begin
         stat_q[win_idx] <= stat_q[win_idx] + 1'b1;
      end
   end

   for (genvar i = 0; i < NREQ; i++) begin : g_stat
      assign grant_cnt[i*STAT_W +: STAT_W] = stat_q[i];
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int NREQ    = 4;
   localparam int DW      = 32;
   localparam int TW      = ALU_TW;
   localparam int ALU_LAT = 1;
   localparam int IW      = 2;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*DW-1:0] req_a;
   logic [NREQ*DW-1:0] req_b;
   logic [NREQ*TW-1:0] req_type;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IW-1:0]     rsp_id;
   logic [DW-1:0]     rsp_data;
   logic [DW-1:0]     alu_a;
   logic [DW-1:0]     alu_b;
   logic [TW-1:0]     alu_type;
   logic [DW-1:0]     alu_out;
`ifdef ALU_ARB_STATS_EN
   logic [NREQ*16-1:0] grant_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   alu_arbiter #(
      .NREQ    (NREQ),
      .DW      (DW),
      .TW      (TW),
      .ALU_LAT (ALU_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_type  (req_type),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_type  (alu_type),
      .alu_out   (alu_out)
`ifdef ALU_ARB_STATS_EN
     ,.grant_cnt (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [TW-1:0] t);
      case (t)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLL:  return a << b[4:0];
         OP_SRL:  return a >> b[4:0];
         default: return '0;
      endcase
   endfunction

   // ALU stand-in: inputs are held for the whole operation, so a combinational
   // result is valid by the capture edge for ALU_LAT = 1.
   assign alu_out = alu_ref(alu_a, alu_b, alu_type);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++)
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   // Transaction model: phase 0 waiting for accept, 1 operation in flight,
   // 2 response offered.
   int              m_phase = 0;
   int              m_ptr   = 0;
   int              m_cnt   = 0;
   int              m_id    = 0;
   int              m_w;
   logic [DW-1:0]   m_a     = '0;
   logic [DW-1:0]   m_b     = '0;
   logic [TW-1:0]   m_t     = '0;
   logic [DW-1:0]   m_data  = '0;
   int              acc_log[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_req_ready", 64'(req_ready), 64'd0);
         check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         check("rst_rsp_data",  64'(rsp_data),  64'd0);
         check("rst_alu_a",     64'(alu_a),     64'd0);
         m_phase = 0;
         m_ptr   = 0;
         m_a = '0; m_b = '0; m_t = '0;
      end else begin
         check("one_hot_ready", 64'($countones(req_ready) <= 1), 64'd1);
         check("alu_a_held",    64'(alu_a),    64'(m_a));
         check("alu_b_held",    64'(alu_b),    64'(m_b));
         check("alu_type_held", 64'(alu_type), 64'(m_t));
         if (m_phase == 0) begin
            m_w = rr_pick(req_valid, m_ptr);
            check("grant", 64'(req_ready), (m_w >= 0) ? (64'd1 << m_w) : 64'd0);
            check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
            if (m_w >= 0) begin
               m_id    = m_w;
               m_a     = req_a[m_w*DW +: DW];
               m_b     = req_b[m_w*DW +: DW];
               m_t     = req_type[m_w*TW +: TW];
               m_data  = alu_ref(m_a, m_b, m_t);
               m_cnt   = ALU_LAT + 1;
               m_phase = 1;
               acc_log.push_back(m_w);
            end
         end else begin
            check("busy_req_ready", 64'(req_ready), 64'd0);
            if (m_phase == 1) begin
               m_cnt--;
               if (m_cnt == 0) m_phase = 2;
            end
            if (m_phase == 1) begin
               check("exec_rsp_valid", 64'(rsp_valid), 64'd0);
            end else begin
               check("rsp_valid", 64'(rsp_valid), 64'd1);
               check("rsp_id",    64'(rsp_id),    64'(m_id));
               check("rsp_data",  64'(rsp_data),  64'(m_data));
               if (rsp_ready) begin
                  m_ptr   = (m_id + 1) % NREQ;
                  m_phase = 0;
               end
            end
         end
      end
   end

   task automatic set_req(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [TW-1:0] t);
      req_a[id*DW +: DW]    = a;
      req_b[id*DW +: DW]    = b;
      req_type[id*TW +: TW] = t;
      req_valid[id]         = 1'b1;
   endtask

   // Waits for requester id to be accepted, then drops its valid after the edge.
   task automatic wait_accept(input int id);
      bit ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            ok = 1'b1;
            break;
         end
      end
      check($sformatf("accept_timeout_req%0d", id), 64'(ok), 64'd1);
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (m_phase == 0 && !rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_timeout", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] cnt_before;
      cnt_before = '0;
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_type  = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_rsp_id", 64'(rsp_id), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Scenario: all requesters valid, round-robin order from pointer 0.
      acc_log.delete();
      for (int i = 0; i < NREQ; i++) set_req(i, 32'(10 * i + 1), 32'(i + 2), OP_SUB);
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         if (acc_log.size() >= 5) break;
      end
      #1;
      req_valid = '0;
      check("rr_log_size", 64'(acc_log.size()), 64'd5);
      if (acc_log.size() >= 5) begin
         check("rr_order0", 64'(acc_log[0]), 64'd0);
         check("rr_order1", 64'(acc_log[1]), 64'd1);
         check("rr_order2", 64'(acc_log[2]), 64'd2);
         check("rr_order3", 64'(acc_log[3]), 64'd3);
         check("rr_order4", 64'(acc_log[4]), 64'd0);
      end

      // Scenario: single request 3+5 ADD, then a 10-cycle response stall.
      wait_idle();
      rsp_ready = 1'b0;
      set_req(0, 32'd3, 32'd5, OP_ADD);
      wait_accept(0);
      set_req(1, 32'h0000_00F0, 32'h0000_003C, OP_AND);
      @(negedge clk);
      check("t1_not_yet_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
      check("t1_rsp_id",    64'(rsp_id),    64'd0);
      check("t1_rsp_data",  64'(rsp_data),  64'd8);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
         check("stall_rsp_data",  64'(rsp_data),  64'd8);
         check("stall_req_ready", 64'(req_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      wait_accept(1);
      @(negedge clk);
      @(negedge clk);
      check("and_rsp_data", 64'(rsp_data), 64'h30);

      // Scenario: reset asserted while an operation is executing.
      wait_idle();
      set_req(2, 32'd100, 32'd7, OP_SUB);
      wait_accept(2);
      rst_n = 1'b0;
      #1;
      check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
      check("abort_alu_a",     64'(alu_a),     64'd0);
      check("abort_alu_type",  64'(alu_type),  64'd0);
      check("abort_rsp_data",  64'(rsp_data),  64'd0);
      for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'd1, OP_SLL);
      #1;
      check("abort_req_ready", 64'(req_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      acc_log.delete();
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_grant", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      check("post_reset_data", 64'(rsp_data), 64'd2);

      // Scenario: serve requester 3, pointer wraps, only requester 2 remains.
      wait_idle();
      set_req(3, 32'h8000_0000, 32'd4, OP_SRL);
      wait_accept(3);
`ifdef ALU_ARB_STATS_EN
      cnt_before = grant_cnt[2*16 +: 16];
`endif
      set_req(2, 32'h0F0F_0000, 32'h00FF_00FF, OP_XOR);
      acc_log.delete();
      wait_accept(2);
      check("wrap_log_size", 64'(acc_log.size()), 64'd1);
      if (acc_log.size() >= 1) check("wrap_grant", 64'(acc_log[0]), 64'd2);
`ifdef ALU_ARB_STATS_EN
      check("stats_cnt2", 64'(grant_cnt[2*16 +: 16]), 64'(cnt_before + 16'd1));
`endif
      @(negedge clk);
      @(negedge clk);
      check("xor_rsp_data", 64'(rsp_data), 64'h0FF0_00FF);

      wait_idle();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
